uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver. It is the receiving end of the 8N1-style link driven by the existing UART transmitter. It samples the `rx` line at mid-bit, assembles `NrOfDataBits` data bits LSB first, checks the stop bit, and presents each received word with a one-cycle strobe. It sits beside the transmitter on the board top level, sharing `CLOCK_50` and the pushbutton-derived reset.

## Interface
Parameters:
- `ClockFrequency`, default 50000000: clock frequency in Hz.
- `BaudRate`, default 9600: line rate in bit/s.
- `NrOfDataBits`, default 8: data bits per frame, legal range 5–9.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-low reset. Sampled on the rising edge of `clock`.
- `rx`, in, 1: serial line. Asynchronous to `clock`. Idles high.
- `dataBits`, out, `NrOfDataBits`: last correctly framed word. Bit 0 is the first data bit received.
- `dataValid`, out, 1: high for one cycle when `dataBits` is updated.
- `frameError`, out, 1: high for one cycle when the stop bit is sampled low.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
Derived constants, computed with integer division:
- BitPeriod = ClockFrequency/BaudRate. Must be at least 4.
- HalfPeriod = BitPeriod/2.

Input conditioning:
- `rx` passes through a 2-flop synchronizer. The synchronized value is rxS.
- Both synchronizer flops reset to 1.
- No other filtering is applied.

Counters:
- A bit-timer counts cycles. Each wait runs the timer from 0 to target−1; the sample is taken on the cycle where the count equals target−1.
- A bit index runs 0..NrOfDataBits−1.

FSM states and transitions:
- IDLE:
  - Timer held at 0.
  - rxS==0 → START.
- START: wait HalfPeriod cycles, then sample rxS.
  - Sample 1 → treat as a glitch and return to IDLE. No outputs change.
  - Sample 0 → DATA, with index = 0.
- DATA: wait BitPeriod cycles, then sample rxS into shift-register position [index].
  - index == NrOfDataBits−1 → STOP.
  - Otherwise increment index.
- STOP: wait BitPeriod cycles, then sample rxS.
  - Sample 1: load `dataBits` from the shift register, pulse `dataValid`, go to IDLE.
  - Sample 0: pulse `frameError`, leave `dataBits` unchanged, go to BREAK.
- BREAK:
  - Remain here while rxS==0.
  - rxS==1 → IDLE. This blocks re-triggering during a line break.

Output rules:
- `dataValid` and `frameError` are registered and are never high in the same cycle.
- `busy` is registered and equals (state ≠ IDLE).

Reset:
- Asserting reset in any state forces on the next edge: state IDLE, timer 0, index 0, `dataBits` all zero, `dataValid` 0, `frameError` 0, `busy` 0, synchronizer 1.
- A frame in progress is discarded and no strobe is produced for it.
- After reset is released, a line held low is treated as a new start bit.

## Timing
Take edge T as the first clock edge at which rxS==0 in IDLE. At T+1 the FSM is in START.

| Event | Clock edge |
|---|---|
| Start-bit check sample | T+HalfPeriod |
| Data bit k (k = 0..N−1) sampled | T+HalfPeriod+(k+1)·BitPeriod |
| Stop bit sampled | T+HalfPeriod+(N+1)·BitPeriod |
| `dataValid` / `frameError` high | cycle after stop sample, one cycle only |

Further timing facts:
- Transitions from the raw `rx` line to rxS take 2 cycles.
- The FSM is back in IDLE in the cycle the strobe is high. A start bit that begins immediately after the stop bit's mid-point is accepted.
- Back-to-back frames with a single stop bit are received without loss.
- Sampling error per frame is at most one clock cycle plus BitPeriod mod 2. Baud mismatch tolerance is the standard ±2% for N=8.

## Test plan
All scenarios use ClockFrequency=16, BaudRate=1 (BitPeriod=16, HalfPeriod=8), N=8, with the stimulus ideal at 16 cycles/bit.

1. **Single frame.** Reset low for 3 cycles, then drive frame 0xA5 with stop=1.
   - Required: `dataBits`=0xA5.
   - Required: one-cycle `dataValid` exactly 2+8+9·16+1 cycles after the `rx` falling edge.
   - Required: `busy` high throughout the frame; `frameError` 0.
2. **Start glitch.** Drive `rx` low for 3 cycles, then high.
   - Required: returns to IDLE; `busy` deasserts by cycle 11 after the glitch.
   - Required: no `dataValid`, no `frameError`; `dataBits` unchanged.
3. **Framing error and break.** Receive 0x3C, then send frame 0x81 with stop=0 and hold `rx` low for 40 more cycles, then release high.
   - Required: `frameError` pulses once; `dataBits` stays 0x3C.
   - Required: `busy` stays high until 2 cycles after release.
   - Required: no spurious frame is received.
4. **Back-to-back frames.** Send 0x00, 0xFF, 0x5A with no idle gap between them.
   - Required: three `dataValid` pulses 160 cycles apart, carrying the correct values in order.
5. **Reset mid-frame.** Assert reset during data bit 4 of 0xC3 for 1 cycle, then send 0x12.
   - Required: all outputs are zero after the reset edge.
   - Required: no strobe for the aborted frame.
   - Required: 0x12 is received correctly.
6. **Short word.** Set NrOfDataBits=5 and send 0x15.
   - Required: `dataBits`=5'h15, `dataValid` after 2+8+6·16+1 cycles.

Source files
------------

// File: rtl/uart_rx.sv
// Asynchronous 8N1-style serial receiver: mid-bit sampling, LSB-first assembly,
// stop-bit check, and one-cycle strobes for good words and framing errors.
module uart_rx #(
    parameter int ClockFrequency = 50000000,
    parameter int BaudRate       = 9600,
    parameter int NrOfDataBits   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    output logic [NrOfDataBits-1:0] dataBits,
    output logic                    dataValid,
    output logic                    frameError,
    output logic                    busy
);

    localparam int BitPeriod  = ClockFrequency / BaudRate;
    localparam int HalfPeriod = BitPeriod / 2;
    localparam int TimerWidth = $clog2(BitPeriod);
    localparam int IndexWidth = (NrOfDataBits > 1) ? $clog2(NrOfDataBits) : 1;

    localparam logic [TimerWidth-1:0] BitLast   = TimerWidth'(BitPeriod - 1);
    localparam logic [TimerWidth-1:0] HalfLast  = TimerWidth'(HalfPeriod - 1);
    localparam logic [IndexWidth-1:0] IndexLast = IndexWidth'(NrOfDataBits - 1);

    generate
        if (BitPeriod < 4) begin : g_bad_period
            $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
        end
        if (NrOfDataBits < 5 || NrOfDataBits > 9) begin : g_bad_width
            $error("uart_rx: NrOfDataBits must lie in 5..9");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                  state;
    logic [TimerWidth-1:0]   timer;
    logic [IndexWidth-1:0]   index;
    logic [NrOfDataBits-1:0] shift_reg;
    logic                    rx_meta;
    logic                    rx_sync;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // busy is updated alongside every state change so it tracks state != IDLE exactly.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            index      <= '0;
            shift_reg  <= '0;
            dataBits   <= '0;
            dataValid  <= 1'b0;
            frameError <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dataValid  <= 1'b0;
            frameError <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    index <= '0;
                    if (!rx_sync) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HalfLast) begin
                        timer <= '0;
                        if (rx_sync) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            index <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BitLast) begin
                        timer            <= '0;
                        shift_reg[index] <= rx_sync;
                        if (index == IndexLast) begin
                            state <= STOP;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == BitLast) begin
                        timer <= '0;
                        if (rx_sync) begin
                            dataBits  <= shift_reg;
                            dataValid <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            frameError <= 1'b1;
                            state      <= BREAK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a break cannot retrigger.
                    timer <= '0;
                    if (rx_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, with an 8-bit and a 5-bit instance.
module tb_uart_rx;

    localparam int BitCycles = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       rx;
    logic [7:0] dataBits;
    logic       dataValid;
    logic       frameError;
    logic       busy;

    logic       reset5;
    logic       rx5;
    logic [4:0] dataBits5;
    logic       dataValid5;
    logic       frameError5;
    logic       busy5;

    uart_rx #(.ClockFrequency(16), .BaudRate(1), .NrOfDataBits(8)) dut (
        .clock(clock), .reset(reset), .rx(rx), .dataBits(dataBits),
        .dataValid(dataValid), .frameError(frameError), .busy(busy)
    );

    uart_rx #(.ClockFrequency(16), .BaudRate(1), .NrOfDataBits(5)) dut5 (
        .clock(clock), .reset(reset5), .rx(rx5), .dataBits(dataBits5),
        .dataValid(dataValid5), .frameError(frameError5), .busy(busy5)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [7:0] exp_q[$];
    logic [4:0] exp5_q[$];
    int         dv_cycles[$];
    int         dv5_cycles[$];
    int         dv_count  = 0;
    int         fe_count  = 0;
    int         dv5_count = 0;
    int         fe5_count = 0;
    logic [7:0] mon_expected;
    logic [4:0] mon5_expected;

    always @(posedge clock) cycle <= cycle + 1;

    // Scoreboard for the 8-bit receiver: every strobe pops the oldest expected word.
    always @(negedge clock) begin
        if (dataValid) begin
            dv_count++;
            dv_cycles.push_back(cycle);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL word8 unexpected strobe got=%h expected=none", dataBits);
            end else begin
                mon_expected = exp_q.pop_front();
                if (dataBits !== mon_expected) begin
                    failures++;
                    $display("[TB] FAIL word8 got=%h expected=%h", dataBits, mon_expected);
                end
            end
        end
        if (frameError) fe_count++;
        if (dataValid || frameError) begin
            checks++;
            if (dataValid && frameError) begin
                failures++;
                $display("[TB] FAIL strobe_exclusive8 got=both expected=one");
            end
        end
    end

    always @(negedge clock) begin
        if (dataValid5) begin
            dv5_count++;
            dv5_cycles.push_back(cycle);
            checks++;
            if (exp5_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL word5 unexpected strobe got=%h expected=none", dataBits5);
            end else begin
                mon5_expected = exp5_q.pop_front();
                if (dataBits5 !== mon5_expected) begin
                    failures++;
                    $display("[TB] FAIL word5 got=%h expected=%h", dataBits5, mon5_expected);
                end
            end
        end
        if (frameError5) fe5_count++;
    end

    // Drives one ideal frame starting at the current negedge; returns at the end of the stop bit.
    task automatic send_frame(input logic [8:0] data, input int nbits, input logic stop,
                              input bit narrow);
        if (narrow) rx5 = 1'b0; else rx = 1'b0;
        repeat (BitCycles) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            if (narrow) rx5 = data[i]; else rx = data[i];
            repeat (BitCycles) @(negedge clock);
        end
        if (narrow) rx5 = stop; else rx = stop;
        repeat (BitCycles) @(negedge clock);
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        reset5 = 1'b0;
        rx     = 1'b1;
        rx5    = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (dataBits !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h expected=00", dataBits); end
        checks++;
        if (dataValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b expected=0", dataValid); end
        checks++;
        if (frameError !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr got=%b expected=0", frameError); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b expected=0", busy); end
        checks++;
        if (dataBits5 !== 5'h00) begin failures++; $display("[TB] FAIL reset_data5 got=%h expected=00", dataBits5); end
        checks++;
        if (busy5 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy5 got=%b expected=0", busy5); end
        reset  = 1'b1;
        reset5 = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b expected=0", busy); end
    endtask

    task automatic test_single_frame;
        int c0, dv0, fe0, busy_lows, latency;
        logic valid_at_stop;
        dv0 = dv_count;
        fe0 = fe_count;
        busy_lows = 0;
        valid_at_stop = 1'b0;
        dv_cycles.delete();
        exp_q.push_back(8'hA5);
        c0 = cycle;
        fork
            send_frame(9'h0A5, 8, 1'b1, 1'b0);
            begin
                repeat (3) @(negedge clock);
                repeat (152) begin
                    if (busy !== 1'b1) busy_lows++;
                    @(negedge clock);
                end
                valid_at_stop = dataValid;
            end
        join
        repeat (4) @(negedge clock);
        checks++;
        if (busy_lows !== 0) begin failures++; $display("[TB] FAIL single_busy got=%0d low cycles expected=0", busy_lows); end
        checks++;
        if (valid_at_stop !== 1'b1) begin failures++; $display("[TB] FAIL single_valid_edge got=%b expected=1", valid_at_stop); end
        latency = (dv_cycles.size() > 0) ? dv_cycles[0] - c0 : -1;
        checks++;
        if (latency !== 155) begin failures++; $display("[TB] FAIL single_latency got=%0d expected=155", latency); end
        checks++;
        if (dv_count - dv0 !== 1) begin failures++; $display("[TB] FAIL single_pulses got=%0d expected=1", dv_count - dv0); end
        checks++;
        if (fe_count - fe0 !== 0) begin failures++; $display("[TB] FAIL single_ferr got=%0d expected=0", fe_count - fe0); end
        checks++;
        if (dataBits !== 8'hA5) begin failures++; $display("[TB] FAIL single_data got=%h expected=a5", dataBits); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle got=%b expected=0", busy); end
    endtask

    task automatic test_start_glitch;
        int dv0, fe0;
        dv0 = dv_count;
        fe0 = fe_count;
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_start got=%b expected=1", busy); end
        repeat (6) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_drop got=%b expected=0", busy); end
        repeat (200) @(negedge clock);
        checks++;
        if (dv_count - dv0 !== 0) begin failures++; $display("[TB] FAIL glitch_valid got=%0d expected=0", dv_count - dv0); end
        checks++;
        if (fe_count - fe0 !== 0) begin failures++; $display("[TB] FAIL glitch_ferr got=%0d expected=0", fe_count - fe0); end
        checks++;
        if (dataBits !== 8'hA5) begin failures++; $display("[TB] FAIL glitch_data got=%h expected=a5", dataBits); end
    endtask

    task automatic test_frame_error;
        int dv1, fe0;
        exp_q.push_back(8'h3C);
        send_frame(9'h03C, 8, 1'b1, 1'b0);
        dv1 = dv_count;
        fe0 = fe_count;
        send_frame(9'h081, 8, 1'b0, 1'b0);
        checks++;
        if (fe_count - fe0 !== 1) begin failures++; $display("[TB] FAIL ferr_pulse got=%0d expected=1", fe_count - fe0); end
        repeat (40) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL break_busy got=%b expected=1", busy); end
        rx = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL release_busy_hold got=%b expected=1", busy); end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL release_busy_drop got=%b expected=0", busy); end
        repeat (30) @(negedge clock);
        checks++;
        if (dv_count !== dv1) begin failures++; $display("[TB] FAIL break_spurious got=%0d expected=%0d", dv_count, dv1); end
        checks++;
        if (dataBits !== 8'h3C) begin failures++; $display("[TB] FAIL ferr_data got=%h expected=3c", dataBits); end
        checks++;
        if (fe_count - fe0 !== 1) begin failures++; $display("[TB] FAIL ferr_total got=%0d expected=1", fe_count - fe0); end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL ferr_pending got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int c0, first, gap1, gap2;
        dv_cycles.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        c0 = cycle;
        send_frame(9'h000, 8, 1'b1, 1'b0);
        send_frame(9'h0FF, 8, 1'b1, 1'b0);
        send_frame(9'h05A, 8, 1'b1, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (dv_cycles.size() !== 3) begin failures++; $display("[TB] FAIL b2b_count got=%0d expected=3", dv_cycles.size()); end
        first = (dv_cycles.size() > 0) ? dv_cycles[0] - c0 : -1;
        gap1  = (dv_cycles.size() > 1) ? dv_cycles[1] - dv_cycles[0] : -1;
        gap2  = (dv_cycles.size() > 2) ? dv_cycles[2] - dv_cycles[1] : -1;
        checks++;
        if (first !== 155) begin failures++; $display("[TB] FAIL b2b_first got=%0d expected=155", first); end
        checks++;
        if (gap1 !== 160) begin failures++; $display("[TB] FAIL b2b_gap1 got=%0d expected=160", gap1); end
        checks++;
        if (gap2 !== 160) begin failures++; $display("[TB] FAIL b2b_gap2 got=%0d expected=160", gap2); end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL b2b_pending got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame;
        int dv0, fe0;
        logic [7:0] aborted;
        aborted = 8'hC3;
        dv0 = dv_count;
        fe0 = fe_count;
        rx = 1'b0;
        repeat (BitCycles) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = aborted[i];
            repeat (BitCycles) @(negedge clock);
        end
        rx = aborted[4];
        repeat (8) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        checks++;
        if (dataBits !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data got=%h expected=00", dataBits); end
        checks++;
        if (dataValid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got=%b expected=0", dataValid); end
        checks++;
        if (frameError !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ferr got=%b expected=0", frameError); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b expected=0", busy); end
        repeat (200) @(negedge clock);
        checks++;
        if (dv_count !== dv0) begin failures++; $display("[TB] FAIL midreset_strobe got=%0d expected=%0d", dv_count, dv0); end
        checks++;
        if (fe_count !== fe0) begin failures++; $display("[TB] FAIL midreset_ferr_count got=%0d expected=%0d", fe_count, fe0); end
        exp_q.push_back(8'h12);
        send_frame(9'h012, 8, 1'b1, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (dv_count !== dv0 + 1) begin failures++; $display("[TB] FAIL after_reset_count got=%0d expected=%0d", dv_count, dv0 + 1); end
        checks++;
        if (dataBits !== 8'h12) begin failures++; $display("[TB] FAIL after_reset_data got=%h expected=12", dataBits); end
    endtask

    task automatic test_short_word;
        int c0, dv0, fe0, latency;
        dv0 = dv5_count;
        fe0 = fe5_count;
        dv5_cycles.delete();
        exp5_q.push_back(5'h15);
        c0 = cycle;
        send_frame(9'h015, 5, 1'b1, 1'b1);
        repeat (4) @(negedge clock);
        latency = (dv5_cycles.size() > 0) ? dv5_cycles[0] - c0 : -1;
        checks++;
        if (latency !== 107) begin failures++; $display("[TB] FAIL short_latency got=%0d expected=107", latency); end
        checks++;
        if (dv5_count - dv0 !== 1) begin failures++; $display("[TB] FAIL short_pulses got=%0d expected=1", dv5_count - dv0); end
        checks++;
        if (dataBits5 !== 5'h15) begin failures++; $display("[TB] FAIL short_data got=%h expected=15", dataBits5); end
        checks++;
        if (fe5_count - fe0 !== 0) begin failures++; $display("[TB] FAIL short_ferr got=%0d expected=0", fe5_count - fe0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_short_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
